// File: rtl/cl_ocl_reg_slv_pkg.sv
// -----------------------------------------------------------------------------
// cl_ocl_reg_slv_pkg
// Shared types and constants for the OCL (BAR0) AXI4-Lite register slave.
//   - register offsets relative to BASE_ADDR
//   - AXI response codes, FSM state enums, register select enum
//   - helper functions: offset decode and byte-strobe merge
// Optional feature macro used by the design: CL_OCL_REG_SLV_ERR_RESP_EN
// -----------------------------------------------------------------------------
package cl_ocl_reg_slv_pkg;

    localparam logic [31:0] OFS_HELLO = 32'h0000_0000;
    localparam logic [31:0] OFS_VLED  = 32'h0000_0004;
    localparam logic [31:0] OFS_VDIP  = 32'h0000_0008;
    localparam logic [31:0] OFS_CNT   = 32'h0000_000C;
    localparam logic [31:0] OFS_ID    = 32'h0000_0010;

    localparam logic [31:0] UNMAPPED_RDATA = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        SLVERR = 2'b10
    } resp_t;

    typedef enum logic [1:0] {
        W_IDLE   = 2'd0,
        W_HAVE_A = 2'd1,
        W_HAVE_D = 2'd2,
        W_RESP   = 2'd3
    } wr_state_t;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_RESP = 1'b1
    } rd_state_t;

    typedef enum logic [2:0] {
        SEL_HELLO = 3'd0,
        SEL_VLED  = 3'd1,
        SEL_VDIP  = 3'd2,
        SEL_CNT   = 3'd3,
        SEL_ID    = 3'd4,
        SEL_NONE  = 3'd5
    } reg_sel_t;

    // Offset -> register select. Anything not word aligned is unmapped.
    function automatic reg_sel_t decode_ofs(input logic [31:0] ofs);
        reg_sel_t sel;
        sel = SEL_NONE;
        if (ofs[1:0] == 2'b00) begin
            case (ofs)
                OFS_HELLO: sel = SEL_HELLO;
                OFS_VLED:  sel = SEL_VLED;
                OFS_VDIP:  sel = SEL_VDIP;
                OFS_CNT:   sel = SEL_CNT;
                OFS_ID:    sel = SEL_ID;
                default:   sel = SEL_NONE;
            endcase
        end
        return sel;
    endfunction

    // Replace only the bytes whose strobe bit is set.
    function automatic logic [31:0] byte_merge(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  strb);
        logic [31:0] res;
        res = old_val;
        for (int i = 0; i < 4; i++) begin
            if (strb[i]) res[i*8 +: 8] = new_val[i*8 +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/cl_ocl_wr_join.sv
// -----------------------------------------------------------------------------
// cl_ocl_wr_join
// Joins the AXI4-Lite AW and W channels (either order, or together) and owns
// the B channel. One outstanding write: nothing new is accepted until the B
// handshake completes.
// Ports:
//   clk_main_a0, rst_main_n          clock, async active-low reset
//   awvalid/awready/awaddr           write address channel
//   wvalid/wready/wdata/wstrb        write data channel
//   bvalid/bready/bresp              write response channel
//   commit                           one-cycle pulse on the edge where the
//                                    address/data pair becomes complete
//   cmt_addr/cmt_data/cmt_strb       the joined write, valid with commit
//   cmt_err                          from the register file: 1 -> SLVERR
//   state_dbg                        current FSM state (wr_state_t encoding)
// Handshake rule: a beat transfers on a rising edge where valid && ready.
// -----------------------------------------------------------------------------
module cl_ocl_wr_join
    import cl_ocl_reg_slv_pkg::*;
(
    input  logic        clk_main_a0,
    input  logic        rst_main_n,
    input  logic        awvalid,
    output logic        awready,
    input  logic [31:0] awaddr,
    input  logic        wvalid,
    output logic        wready,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    output logic        bvalid,
    input  logic        bready,
    output logic [1:0]  bresp,
    output logic        commit,
    output logic [31:0] cmt_addr,
    output logic [31:0] cmt_data,
    output logic [3:0]  cmt_strb,
    input  logic        cmt_err,
    output logic [1:0]  state_dbg
);

    wr_state_t   state;
    logic [31:0] addr_q;
    logic [31:0] data_q;
    logic [3:0]  strb_q;
    logic        aw_hs;
    logic        w_hs;

    assign aw_hs     = awvalid & awready;
    assign w_hs      = wvalid & wready;
    assign state_dbg = state;

    // The commit is combinational so the register file writes on the same
    // edge that accepts the second half of the pair.
    always_comb begin
        commit   = 1'b0;
        cmt_addr = awaddr;
        cmt_data = wdata;
        cmt_strb = wstrb;
        case (state)
            W_IDLE:   commit = aw_hs & w_hs;
            W_HAVE_A: begin
                commit   = w_hs;
                cmt_addr = addr_q;
            end
            W_HAVE_D: begin
                commit   = aw_hs;
                cmt_data = data_q;
                cmt_strb = strb_q;
            end
            default:  commit = 1'b0;
        endcase
    end

    // Readies are registered; they come up one edge after reset release.
    always_ff @(posedge clk_main_a0 or negedge rst_main_n) begin
        if (!rst_main_n) begin
            state   <= W_IDLE;
            awready <= 1'b0;
            wready  <= 1'b0;
            bvalid  <= 1'b0;
            bresp   <= OKAY;
            addr_q  <= '0;
            data_q  <= '0;
            strb_q  <= '0;
        end else begin
            if (aw_hs) addr_q <= awaddr;
            if (w_hs) begin
                data_q <= wdata;
                strb_q <= wstrb;
            end
            if (commit) begin
                state   <= W_RESP;
                awready <= 1'b0;
                wready  <= 1'b0;
                bvalid  <= 1'b1;
                bresp   <= cmt_err ? SLVERR : OKAY;
            end else begin
                case (state)
                    W_IDLE: begin
                        awready <= 1'b1;
                        wready  <= 1'b1;
                        if (aw_hs) begin
                            state   <= W_HAVE_A;
                            awready <= 1'b0;
                        end else if (w_hs) begin
                            state  <= W_HAVE_D;
                            wready <= 1'b0;
                        end
                    end
                    W_RESP: begin
                        if (bready) begin
                            state   <= W_IDLE;
                            bvalid  <= 1'b0;
                            awready <= 1'b1;
                            wready  <= 1'b1;
                        end
                    end
                    default: begin
                        // W_HAVE_A / W_HAVE_D wait for the other half
                    end
                endcase
            end
        end
    end

endmodule

// File: rtl/cl_ocl_reg_slv.sv
// -----------------------------------------------------------------------------
// cl_ocl_reg_slv
// AXI4-Lite slave on the OCL (BAR0) channel. Single-beat accesses into a small
// register file:
//   +0x00 HELLO RW (reads return the halfword-swapped value)
//   +0x04 VLED  RW bits [15:0], drives cl_sh_status_vled
//   +0x08 VDIP  RO two-flop synchronised sh_cl_status_vdip
//   +0x0C CNT   RO free-running cycle counter
//   +0x10 ID    RO ID_VALUE
// Ports: clk_main_a0, rst_main_n (async active-low); AW/W/B and AR/R AXI4-Lite
// channels; sh_cl_status_vdip in, cl_sh_status_vled out.
// Write and read channels are independent, one outstanding each.
// Handshake rule: a beat transfers on a rising edge where valid && ready;
// bvalid/rvalid and their payloads hold until the matching ready.
// Macro CL_OCL_REG_SLV_ERR_RESP_EN: when defined, unmapped/misaligned accesses
// and writes to RO registers return SLVERR (reads with rdata 0); otherwise all
// responses are OKAY, unmapped reads return 0xDEAD_BEEF and bad writes are
// dropped.
// DEC_W must be below 32; bits above DEC_W of the address are ignored.
// -----------------------------------------------------------------------------
module cl_ocl_reg_slv
    import cl_ocl_reg_slv_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0500,
    parameter logic [31:0] ID_VALUE  = 32'hF000_1D0F,
    parameter int          DEC_W     = 12
) (
    input  logic        clk_main_a0,
    input  logic        rst_main_n,
    input  logic        awvalid,
    output logic        awready,
    input  logic [31:0] awaddr,
    input  logic        wvalid,
    output logic        wready,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    output logic        bvalid,
    input  logic        bready,
    output logic [1:0]  bresp,
    input  logic        arvalid,
    output logic        arready,
    input  logic [31:0] araddr,
    output logic        rvalid,
    input  logic        rready,
    output logic [31:0] rdata,
    output logic [1:0]  rresp,
    input  logic [15:0] sh_cl_status_vdip,
    output logic [15:0] cl_sh_status_vled
);

    localparam logic [DEC_W-1:0] BASE_DEC = BASE_ADDR[DEC_W-1:0];

    // ---------------- write join ----------------
    logic        wr_commit;
    logic [31:0] cmt_addr;
    logic [31:0] cmt_data;
    logic [3:0]  cmt_strb;
    logic        wr_err;
    logic [1:0]  wr_state_dbg;

    cl_ocl_wr_join u_wr_join (
        .clk_main_a0 (clk_main_a0),
        .rst_main_n  (rst_main_n),
        .awvalid     (awvalid),
        .awready     (awready),
        .awaddr      (awaddr),
        .wvalid      (wvalid),
        .wready      (wready),
        .wdata       (wdata),
        .wstrb       (wstrb),
        .bvalid      (bvalid),
        .bready      (bready),
        .bresp       (bresp),
        .commit      (wr_commit),
        .cmt_addr    (cmt_addr),
        .cmt_data    (cmt_data),
        .cmt_strb    (cmt_strb),
        .cmt_err     (wr_err),
        .state_dbg   (wr_state_dbg)
    );

    // ---------------- decode ----------------
    logic [DEC_W-1:0] wr_ofs;
    logic [DEC_W-1:0] rd_ofs;
    reg_sel_t         wr_sel;
    reg_sel_t         rd_sel;

    assign wr_ofs = cmt_addr[DEC_W-1:0] - BASE_DEC;
    assign rd_ofs = araddr[DEC_W-1:0] - BASE_DEC;
    assign wr_sel = decode_ofs(32'(wr_ofs));
    assign rd_sel = decode_ofs(32'(rd_ofs));

`ifdef CL_OCL_REG_SLV_ERR_RESP_EN
    assign wr_err = !(wr_sel == SEL_HELLO || wr_sel == SEL_VLED);
`else
    assign wr_err = 1'b0;
`endif

    // ---------------- register file ----------------
    logic [31:0] hello_q;
    logic [15:0] vled_q;
    logic [31:0] cnt_q;
    logic [15:0] vdip_meta;
    logic [15:0] vdip_sync;
    logic [31:0] vled_new;

    assign vled_new          = byte_merge({16'h0000, vled_q}, cmt_data, cmt_strb);
    assign cl_sh_status_vled = vled_q;

    always_ff @(posedge clk_main_a0 or negedge rst_main_n) begin
        if (!rst_main_n) begin
            hello_q <= '0;
            vled_q  <= '0;
        end else if (wr_commit) begin
            // Only RW registers ever change; other selects are dropped here.
            if (wr_sel == SEL_HELLO) hello_q <= byte_merge(hello_q, cmt_data, cmt_strb);
            if (wr_sel == SEL_VLED)  vled_q  <= vled_new[15:0];
        end
    end

    always_ff @(posedge clk_main_a0 or negedge rst_main_n) begin
        if (!rst_main_n) cnt_q <= '0;
        else             cnt_q <= cnt_q + 32'd1;
    end

    always_ff @(posedge clk_main_a0 or negedge rst_main_n) begin
        if (!rst_main_n) begin
            vdip_meta <= '0;
            vdip_sync <= '0;
        end else begin
            vdip_meta <= sh_cl_status_vdip;
            vdip_sync <= vdip_meta;
        end
    end

    // ---------------- read path ----------------
    rd_state_t   rd_state;
    logic        ar_hs;
    logic [31:0] rd_val;
    logic [1:0]  rd_resp;

    assign ar_hs = arvalid & arready;

    // Values are taken before this edge's updates, so a read colliding with
    // a write commit sees the old contents, and CNT is the acceptance value.
    always_comb begin
        rd_val  = '0;
        rd_resp = OKAY;
        case (rd_sel)
            SEL_HELLO: rd_val = {hello_q[15:0], hello_q[31:16]};
            SEL_VLED:  rd_val = {16'h0000, vled_q};
            SEL_VDIP:  rd_val = {16'h0000, vdip_sync};
            SEL_CNT:   rd_val = cnt_q;
            SEL_ID:    rd_val = ID_VALUE;
            default: begin
`ifdef CL_OCL_REG_SLV_ERR_RESP_EN
                rd_val  = '0;
                rd_resp = SLVERR;
`else
                rd_val  = UNMAPPED_RDATA;
                rd_resp = OKAY;
`endif
            end
        endcase
    end

    always_ff @(posedge clk_main_a0 or negedge rst_main_n) begin
        if (!rst_main_n) begin
            rd_state <= R_IDLE;
            arready  <= 1'b0;
            rvalid   <= 1'b0;
            rdata    <= '0;
            rresp    <= OKAY;
        end else begin
            case (rd_state)
                R_IDLE: begin
                    arready <= 1'b1;
                    if (ar_hs) begin
                        rd_state <= R_RESP;
                        arready  <= 1'b0;
                        rvalid   <= 1'b1;
                        rdata    <= rd_val;
                        rresp    <= rd_resp;
                    end
                end
                R_RESP: begin
                    if (rready) begin
                        rd_state <= R_IDLE;
                        rvalid   <= 1'b0;
                        arready  <= 1'b1;
                    end
                end
                default: rd_state <= R_IDLE;
            endcase
        end
    end

    // Address bits above DEC_W and the write FSM debug state are not used here.
    logic unused_ok;
    assign unused_ok = ^{cmt_addr[31:DEC_W], araddr[31:DEC_W], vled_new[31:16], wr_state_dbg};

endmodule
